// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction fetch/decode sequencer for a small 16-bit processor. It fetches
// an instruction word from memory into the instruction register, decodes the
// opcode for one cycle and drives the address-select and PC-load strobes.
// Loads and stores get an extra memory phase followed by a PC increment.
// Every memory wait is bounded by MEM_TIMEOUT. On expiry the sequencer flags
// MemError and parks in HALT until the next ExternalReset.
//
// Parameters
//   MEM_TIMEOUT   maximum cycles to wait for MemDataReady (1..255)
//
// Ports
//   clk           single clock, rising edge
//   ExternalReset asynchronous, active-high reset
//   MemDataReady  memory completed the current read or write
//   Instruction   memory data bus, captured into IR on a fetch completion
//   Zflag         zero flag, consulted by BRZ in the DECODE cycle only
//   ResetPC       address select: PC <- reset vector
//   PCplusI       address select: PC + immediate
//   PCplus1       address select: PC + 1
//   RplusI        address select: register + immediate (memory operand)
//   Rplus0        address select: register (jump through register)
//   PCenable      PC load strobe
//   ReadMem       memory read request
//   WriteMem      memory write request
//   IRout         instruction register; IRout[7:0] is the immediate
//   Halted        sequencer is in HALT
//   MemError      a memory wait timed out
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        ExternalReset,
    input  logic        MemDataReady,
    input  logic [15:0] Instruction,
    input  logic        Zflag,
    output logic        ResetPC,
    output logic        PCplusI,
    output logic        PCplus1,
    output logic        RplusI,
    output logic        Rplus0,
    output logic        PCenable,
    output logic        ReadMem,
    output logic        WriteMem,
    output logic [15:0] IRout,
    output logic        Halted,
    output logic        MemError
);

    // Opcodes held in IR[15:12]
    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_HALT   = 4'b0001;
    localparam logic [3:0] OP_JMPR   = 4'b0010;
    localparam logic [3:0] OP_BRZ    = 4'b0011;
    localparam logic [3:0] OP_JMPREG = 4'b0100;
    localparam logic [3:0] OP_LDR    = 4'b0101;
    localparam logic [3:0] OP_STR    = 4'b0110;

    // The wait counter holds the number of not-ready cycles already spent in
    // the current memory phase. A not-ready cycle seen while it equals
    // MEM_TIMEOUT-1 is the one that makes the count reach MEM_TIMEOUT, so a
    // phase lasts at most MEM_TIMEOUT cycles and readiness in the last of
    // them still counts as success.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMOP  = 3'd3,
        S_INCPC  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_ir;
    logic [7:0]  r_wait;
    logic        r_mem_error;

    logic [3:0]  w_opcode;
    logic        w_timeout;

    assign w_opcode  = r_ir[15:12];
    assign w_timeout = !MemDataReady && (r_wait == WAIT_LAST);

    // -------------------------------------------------------------------------
    // State, instruction register, wait counter and error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            r_state     <= S_RST;
            r_ir        <= 16'h0000;
            r_wait      <= 8'd0;
            r_mem_error <= 1'b0;
        end else begin
            case (r_state)
                S_RST: begin
                    r_state <= S_FETCH;
                    r_wait  <= 8'd0;
                end

                S_FETCH: begin
                    if (MemDataReady) begin
                        r_ir    <= Instruction;
                        r_state <= S_DECODE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (w_timeout) begin
                            r_mem_error <= 1'b1;
                            r_state     <= S_HALT;
                        end
                    end
                end

                S_DECODE: begin
                    // Every exit from DECODE enters FETCH or MEMOP (or HALT,
                    // where the counter is irrelevant), so clear it here.
                    r_wait <= 8'd0;
                    case (w_opcode)
                        OP_HALT:        r_state <= S_HALT;
                        OP_LDR, OP_STR: r_state <= S_MEMOP;
                        default:        r_state <= S_FETCH;
                    endcase
                end

                S_MEMOP: begin
                    if (MemDataReady) begin
                        r_state <= S_INCPC;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                        if (w_timeout) begin
                            r_mem_error <= 1'b1;
                            r_state     <= S_HALT;
                        end
                    end
                end

                S_INCPC: begin
                    r_state <= S_FETCH;
                    r_wait  <= 8'd0;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_RST;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // Outputs are decoded from the state and IR rather than registered: BRZ
    // must look at Zflag during the DECODE cycle itself, and an asynchronous
    // reset must pull the memory strobes down without waiting for an edge.
    // -------------------------------------------------------------------------
    always_comb begin
        ResetPC  = 1'b0;
        PCplusI  = 1'b0;
        PCplus1  = 1'b0;
        RplusI   = 1'b0;
        Rplus0   = 1'b0;
        PCenable = 1'b0;
        ReadMem  = 1'b0;
        WriteMem = 1'b0;
        Halted   = 1'b0;

        case (r_state)
            S_RST: begin
                ResetPC  = 1'b1;
                PCenable = 1'b1;
            end

            S_FETCH: begin
                ReadMem = 1'b1;
            end

            S_DECODE: begin
                case (w_opcode)
                    OP_HALT, OP_LDR, OP_STR: begin
                        PCenable = 1'b0;
                    end
                    OP_JMPR: begin
                        PCplusI  = 1'b1;
                        PCenable = 1'b1;
                    end
                    OP_BRZ: begin
                        PCplusI  = Zflag;
                        PCplus1  = !Zflag;
                        PCenable = 1'b1;
                    end
                    OP_JMPREG: begin
                        Rplus0   = 1'b1;
                        PCenable = 1'b1;
                    end
                    // NOP and every unassigned opcode advance the PC by one
                    default: begin
                        PCplus1  = 1'b1;
                        PCenable = 1'b1;
                    end
                endcase
            end

            S_MEMOP: begin
                RplusI   = 1'b1;
                ReadMem  = (w_opcode == OP_LDR);
                WriteMem = (w_opcode == OP_STR);
            end

            S_INCPC: begin
                PCplus1  = 1'b1;
                PCenable = 1'b1;
            end

            S_HALT: begin
                Halted = 1'b1;
            end

            default: begin
                Halted = 1'b0;
            end
        endcase
    end

    assign IRout    = r_ir;
    assign MemError = r_mem_error;

    // OP_NOP is named for readability of the opcode map; NOP shares the
    // default decode path with the unassigned opcodes.
    logic w_is_nop;
    assign w_is_nop = (w_opcode == OP_NOP);
    logic w_unused;
    assign w_unused = w_is_nop;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. Each instruction is expanded by a
// transaction-level model into its expected per-cycle output pattern
// (FETCH wait cycles, DECODE, optional MEMOP and INCPC, or HALT), and the
// DUT outputs are compared cycle by cycle. Directed cases cover the reset,
// decode table, load/store latency, both timeouts and an asynchronous reset
// during a store; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int T = 15;

    // Output vector bit positions
    localparam logic [9:0] B_RESETPC  = 10'b10_0000_0000;
    localparam logic [9:0] B_PCPLUSI  = 10'b01_0000_0000;
    localparam logic [9:0] B_PCPLUS1  = 10'b00_1000_0000;
    localparam logic [9:0] B_RPLUSI   = 10'b00_0100_0000;
    localparam logic [9:0] B_RPLUS0   = 10'b00_0010_0000;
    localparam logic [9:0] B_PCENABLE = 10'b00_0001_0000;
    localparam logic [9:0] B_READMEM  = 10'b00_0000_1000;
    localparam logic [9:0] B_WRITEMEM = 10'b00_0000_0100;
    localparam logic [9:0] B_HALTED   = 10'b00_0000_0010;
    localparam logic [9:0] B_MEMERROR = 10'b00_0000_0001;

    localparam logic [9:0] V_NONE  = 10'b0;
    localparam logic [9:0] V_RST   = B_RESETPC | B_PCENABLE;
    localparam logic [9:0] V_FETCH = B_READMEM;
    localparam logic [9:0] V_P1    = B_PCPLUS1 | B_PCENABLE;
    localparam logic [9:0] V_PI    = B_PCPLUSI | B_PCENABLE;
    localparam logic [9:0] V_R0    = B_RPLUS0 | B_PCENABLE;
    localparam logic [9:0] V_LDR   = B_RPLUSI | B_READMEM;
    localparam logic [9:0] V_STR   = B_RPLUSI | B_WRITEMEM;
    localparam logic [9:0] V_HALT  = B_HALTED;
    localparam logic [9:0] V_ERR   = B_HALTED | B_MEMERROR;

    logic        clk;
    logic        ExternalReset;
    logic        MemDataReady;
    logic [15:0] Instruction;
    logic        Zflag;
    logic        ResetPC, PCplusI, PCplus1, RplusI, Rplus0;
    logic        PCenable, ReadMem, WriteMem;
    logic [15:0] IRout;
    logic        Halted, MemError;
    logic [9:0]  outs;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] model_ir = 16'h0000;
    bit          halted = 1'b0;

    fetch_sequencer #(
        .MEM_TIMEOUT(T)
    ) dut (
        .clk          (clk),
        .ExternalReset(ExternalReset),
        .MemDataReady (MemDataReady),
        .Instruction  (Instruction),
        .Zflag        (Zflag),
        .ResetPC      (ResetPC),
        .PCplusI      (PCplusI),
        .PCplus1      (PCplus1),
        .RplusI       (RplusI),
        .Rplus0       (Rplus0),
        .PCenable     (PCenable),
        .ReadMem      (ReadMem),
        .WriteMem     (WriteMem),
        .IRout        (IRout),
        .Halted       (Halted),
        .MemError     (MemError)
    );

    assign outs = {ResetPC, PCplusI, PCplus1, RplusI, Rplus0,
                   PCenable, ReadMem, WriteMem, Halted, MemError};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs after the falling edge, then compare.
    task automatic step(input string tag, input logic mdr, input logic [15:0] ins,
                        input logic z, input logic [9:0] ev, input logic [15:0] eir);
        @(negedge clk);
        MemDataReady = mdr;
        Instruction  = ins;
        Zflag        = z;
        #1;
        check_eq(tag, 32'(outs), 32'(ev));
        check_eq({tag, ".ir"}, 32'(IRout), 32'(eir));
    endtask

    // Expected DECODE-cycle outputs from the opcode table.
    function automatic logic [9:0] dec_vec(input logic [3:0] op, input logic z);
        case (op)
            4'd1:       return V_NONE;
            4'd2:       return V_PI;
            4'd3:       return z ? V_PI : V_P1;
            4'd4:       return V_R0;
            4'd5, 4'd6: return V_NONE;
            default:    return V_P1;
        endcase
    endfunction

    task automatic rst_release();
        @(negedge clk);
        ExternalReset = 1'b0;
        MemDataReady  = rbit();
        #1;
        check_eq("rst_rel", 32'(outs), 32'(V_RST));
        check_eq("rst_rel.ir", 32'(IRout), 32'h0);
        model_ir = 16'h0000;
        halted   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ExternalReset = 1'b1;
        #1;
        check_eq("rst", 32'(outs), 32'(V_RST));
        check_eq("rst.ir", 32'(IRout), 32'h0);
        for (int i = 0; i < 2; i++)
            step("rst_hold", rbit(), 16'($urandom), rbit(), V_RST, 16'h0000);
        rst_release();
    endtask

    // Expand one instruction into its expected cycle sequence.
    // n: cycle of the fetch on which memory becomes ready (n > T: never).
    // m: same for the MEMOP phase of LDR/STR.
    task automatic do_instr(input logic [15:0] instr, input int n, input int m);
        logic        z;
        logic [15:0] ins;
        logic [9:0]  mem_v;
        if (n > T) begin
            for (int i = 0; i < T; i++)
                step("fetch_wait", 1'b0, 16'($urandom), rbit(), V_FETCH, model_ir);
            for (int i = 0; i < 3; i++)
                step("fetch_timeout", rbit(), 16'($urandom), rbit(), V_ERR, model_ir);
            halted = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            ins = (i == n - 1) ? instr : 16'($urandom);
            step("fetch", (i == n - 1), ins, rbit(), V_FETCH, model_ir);
        end
        model_ir = instr;
        z = rbit();
        step("decode", rbit(), 16'($urandom), z, dec_vec(instr[15:12], z), model_ir);
        case (instr[15:12])
            4'd1: begin
                for (int i = 0; i < 3; i++)
                    step("halt", rbit(), 16'($urandom), rbit(), V_HALT, model_ir);
                halted = 1'b1;
            end
            4'd5, 4'd6: begin
                mem_v = (instr[15:12] == 4'd5) ? V_LDR : V_STR;
                if (m > T) begin
                    for (int i = 0; i < T; i++)
                        step("memop_wait", 1'b0, 16'($urandom), rbit(), mem_v, model_ir);
                    for (int i = 0; i < 3; i++)
                        step("memop_timeout", rbit(), 16'($urandom), rbit(), V_ERR, model_ir);
                    halted = 1'b1;
                end else begin
                    for (int i = 0; i < m; i++)
                        step("memop", (i == m - 1), 16'($urandom), rbit(), mem_v, model_ir);
                    step("incpc", rbit(), 16'($urandom), rbit(), V_P1, model_ir);
                end
            end
            default: ;
        endcase
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14)       return int'($urandom_range(1, 4));
        else if (r < 17)  return T;
        else if (r == 17) return T + 1;
        else              return int'($urandom_range(1, T));
    endfunction

    initial begin
        ExternalReset = 1'b1;
        MemDataReady  = 1'b0;
        Instruction   = 16'h0000;
        Zflag         = 1'b0;

        do_reset();

        // Ready tied high, NOPs: PCplus1+PCenable every second cycle
        for (int i = 0; i < 4; i++) do_instr(16'h0000, 1, 1);

        // Jumps and branches
        do_instr(16'h2005, 1, 1);
        check_eq("jmpr.imm", 32'(IRout[7:0]), 32'h05);
        do_instr(16'h3005, 2, 1);
        do_instr(16'h4abc, 1, 1);
        do_instr(16'hF123, 3, 1);

        // Load with ready on the 4th MEMOP cycle, store with immediate ready
        do_instr(16'h5010, 1, 4);
        do_instr(16'h6020, 2, 1);

        // Readiness on the last permitted cycle succeeds
        do_instr(16'h0000, T, 1);
        do_instr(16'h5011, 1, T);

        // Fetch timeout, then HALT held until reset
        do_instr(16'h0000, T + 1, 1);
        do_reset();

        // HALT opcode
        do_instr(16'h1000, 1, 1);
        do_reset();

        // MEMOP timeout on a store
        do_instr(16'h6000, 1, T + 1);
        do_reset();

        // Asynchronous reset in the middle of a store
        step("str_fetch", 1'b1, 16'h6abc, rbit(), V_FETCH, model_ir);
        model_ir = 16'h6abc;
        step("str_decode", 1'b0, 16'($urandom), rbit(), V_NONE, model_ir);
        step("str_memop", 1'b0, 16'($urandom), rbit(), V_STR, model_ir);
        step("str_memop", 1'b0, 16'($urandom), rbit(), V_STR, model_ir);
        #2;
        ExternalReset = 1'b1;
        #1;
        check_eq("async_rst", 32'(outs), 32'(V_RST));
        check_eq("async_rst.ir", 32'(IRout), 32'h0);
        step("async_rst_hold", 1'b1, 16'($urandom), rbit(), V_RST, 16'h0000);
        rst_release();
        do_instr(16'h2007, 1, 1);

        // Randomized instruction stream
        for (int k = 0; k < 150; k++) begin
            logic [15:0] w;
            w = 16'($urandom);
            do_instr(w, pick_delay(), pick_delay());
            if (halted) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
